// File: rtl/jedro_1_dmem_pkg.sv
// Shared types for the jedro_1 data-memory arbiter: port ids, byte-enable width, command struct.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package jedro_1_dmem_pkg;

    localparam int unsigned DMEM_DATA_WIDTH = 32;
    localparam int unsigned DMEM_ADDR_WIDTH = 32;
    localparam int unsigned BE_WIDTH        = DMEM_DATA_WIDTH / 8;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_AUX  = 1'b1
    } dmem_port_e;

    // Command fields carried through the grant mux; widths track the default bus.
    typedef struct packed {
        logic                       we;
        logic [BE_WIDTH-1:0]        be;
        logic [DMEM_ADDR_WIDTH-1:0] addr;
        logic [DMEM_DATA_WIDTH-1:0] wdata;
    } dmem_cmd_t;

endpackage

// File: rtl/jedro_1_starve_ctr.sv
// Saturating count of consecutive denied cycles on the aux port; raises force_o at STARVE_LIMIT.
// Latency: force_o is a pure function of the registered count (no combinational input path).
// Backpressure: none; count clears on any aux grant or when the aux port stops requesting.
module jedro_1_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic m1_req_i,
    input  logic m1_gnt_i,
    output logic force_o
);
    import jedro_1_dmem_pkg::*;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt_q <= '0;
        end else if (!m1_req_i || m1_gnt_i) begin
            starve_cnt_q <= '0;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_q <= starve_cnt_q + 8'd1;
        end
    end

    assign force_o = (starve_cnt_q == LIMIT);

endmodule

// File: rtl/jedro_1_dmem_arbiter.sv
// Two-port fixed-priority arbiter (core > aux) for the shared bytewrite data RAM; optional aux starvation guard under JEDRO_1_DMEM_ARB_STARVE_EN.
// Latency: grant and RAM command are combinational; read data returns 1 cycle after the grant, steered to the issuing port.
// Backpressure: a denied requester holds its command until gnt; one access per cycle, no internal buffering.
module jedro_1_dmem_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
    import jedro_1_dmem_pkg::*;

    logic       force_m1;
    logic       sel_m1;
    logic       win;
    dmem_cmd_t  cmd;
    dmem_port_e owner_q;
    logic       rd_pend_q;

`ifdef JEDRO_1_DMEM_ARB_STARVE_EN
    jedro_1_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .m1_req_i (m1_req_i),
        .m1_gnt_i (m1_gnt_o),
        .force_o  (force_m1)
    );
`else
    logic [7:0] unused_starve_limit;
    assign unused_starve_limit = 8'(STARVE_LIMIT);
    assign force_m1            = 1'b0;
`endif

    // Grants are gated by reset so nothing is accepted while rstn_i is low.
    assign sel_m1   = m1_req_i & (~m0_req_i | force_m1);
    assign m1_gnt_o = rstn_i & sel_m1;
    assign m0_gnt_o = rstn_i & m0_req_i & ~sel_m1;
    assign win      = m0_gnt_o | m1_gnt_o;

    always_comb begin
        cmd = '0;
        if (m0_gnt_o) begin
            cmd.we    = m0_we_i;
            cmd.be    = m0_be_i;
            cmd.addr  = m0_addr_i;
            cmd.wdata = m0_wdata_i;
        end else if (m1_gnt_o) begin
            cmd.we    = m1_we_i;
            cmd.be    = m1_be_i;
            cmd.addr  = m1_addr_i;
            cmd.wdata = m1_wdata_i;
        end
    end

    assign ram_en_o    = win;
    assign ram_we_o    = cmd.we;
    assign ram_be_o    = cmd.be;
    assign ram_addr_o  = cmd.addr;
    assign ram_wdata_o = cmd.wdata;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q   <= PORT_CORE;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= win & ~cmd.we;
            if (win && !cmd.we) begin
                owner_q <= m1_gnt_o ? PORT_AUX : PORT_CORE;
            end
        end
    end

    // Both ports see the raw RAM data; rvalid alone tells the owner its response has arrived.
    assign m0_rvalid_o = rd_pend_q & (owner_q == PORT_CORE);
    assign m1_rvalid_o = rd_pend_q & (owner_q == PORT_AUX);
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// Bench for jedro_1_dmem_arbiter: behavioural RAM, reference memory and a read-response scoreboard.
module tb_jedro_1_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ram_mem [0:63];
    logic [31:0] ref_mem [0:63];

    always #5 clk = ~clk;

    jedro_1_dmem_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .STARVE_LIMIT (3)
    ) dut (
        .clk_i (clk), .rstn_i (rstn),
        .m0_req_i (m0_req), .m0_we_i (m0_we), .m0_be_i (m0_be), .m0_addr_i (m0_addr), .m0_wdata_i (m0_wdata),
        .m0_gnt_o (m0_gnt), .m0_rvalid_o (m0_rvalid), .m0_rdata_o (m0_rdata),
        .m1_req_i (m1_req), .m1_we_i (m1_we), .m1_be_i (m1_be), .m1_addr_i (m1_addr), .m1_wdata_i (m1_wdata),
        .m1_gnt_o (m1_gnt), .m1_rvalid_o (m1_rvalid), .m1_rdata_o (m1_rdata),
        .ram_en_o (ram_en), .ram_we_o (ram_we), .ram_be_o (ram_be), .ram_addr_o (ram_addr),
        .ram_wdata_o (ram_wdata), .ram_rdata_i (ram_rdata)
    );

    // Behavioural bytewrite RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr[7:2]];
            end
        end
    end

    // Scoreboard: check responses owed from last cycle, then record what this cycle's grant owes.
    always @(negedge clk) begin
        if (!rstn) begin
            n_tests++;
            if ({m0_gnt, m1_gnt, ram_en, m0_rvalid, m1_rvalid} !== 5'b0) begin
                n_fail++; $display("FAIL sb_reset_quiet: got %b required 00000", {m0_gnt, m1_gnt, ram_en, m0_rvalid, m1_rvalid});
            end
            exp_q.delete();
        end else begin
            if (m0_rvalid || m1_rvalid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_unexpected_rvalid: got rvalid0=%b rvalid1=%b required none", m0_rvalid, m1_rvalid);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({m0_rvalid, m1_rvalid} !== {~e.port, e.port}) begin
                        n_fail++; $display("FAIL sb_route: got rvalid0/1=%b%b required port %0d", m0_rvalid, m1_rvalid, e.port);
                    end else if ((e.port ? m1_rdata : m0_rdata) !== e.data) begin
                        n_fail++; $display("FAIL sb_rdata: got %h required %h", e.port ? m1_rdata : m0_rdata, e.data);
                    end
                end
            end else if (exp_q.size() != 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_missing_rvalid: got no rvalid required port %0d", exp_q[0].port);
                exp_q.delete();
            end
            if (m0_gnt || m1_gnt) begin
                logic        p;
                logic        we;
                logic [3:0]  be;
                logic [31:0] addr, wd;
                p    = m1_gnt;
                we   = p ? m1_we : m0_we;
                be   = p ? m1_be : m0_be;
                addr = p ? m1_addr : m0_addr;
                wd   = p ? m1_wdata : m0_wdata;
                n_tests++;
                if (m0_gnt && m1_gnt) begin
                    n_fail++; $display("FAIL sb_double_gnt: got both grants required one");
                end else if ({ram_en, ram_we, ram_addr} !== {1'b1, we, addr} || (we && {ram_be, ram_wdata} !== {be, wd})) begin
                    n_fail++; $display("FAIL sb_ram_cmd: got en=%b we=%b addr=%h be=%h wd=%h required port %0d cmd", ram_en, ram_we, ram_addr, ram_be, ram_wdata, p);
                end
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[addr[7:2]][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    exp_q.push_back('{port: p, data: ref_mem[addr[7:2]]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic test_reset();
        rstn = 0; idle_all(); m0_req = 1; m1_req = 1;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt, ram_en, m0_rvalid, m1_rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required 00000", {m0_gnt, m1_gnt, ram_en, m0_rvalid, m1_rvalid});
        end
        tick(); rstn = 1; idle_all();
        @(negedge clk);
        n_tests++;
        if ({ram_en, ram_we, ram_be, ram_addr, ram_wdata} !== 70'b0) begin
            n_fail++; $display("FAIL idle_ram_zero: got en=%b we=%b be=%h addr=%h wd=%h required all 0", ram_en, ram_we, ram_be, ram_addr, ram_wdata);
        end
        tick();
    endtask

    task automatic test_port0();
        m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL p0_write_gnt: got %b required 10", {m0_gnt, m1_gnt}); end
        tick(); m0_we = 0; m0_be = 4'h3; m0_wdata = 32'h0;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m0_rvalid, m1_rvalid} !== 3'b100) begin n_fail++; $display("FAIL p0_read_gnt: got %b required 100", {m0_gnt, m0_rvalid, m1_rvalid}); end
        tick(); idle_all();
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL p0_rdata: got rv=%b%b data=%h required 10 deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
        end
        tick();
    endtask

    task automatic test_byte_write();
        m1_req = 1; m1_we = 1; m1_be = 4'h1; m1_addr = 32'h10; m1_wdata = 32'h000000AA;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL bw_gnt: got %b required 01", {m0_gnt, m1_gnt}); end
        tick(); m1_we = 0; m1_be = 4'h0;
        @(negedge clk);
        tick(); idle_all();
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hDEADBEAA) begin
            n_fail++; $display("FAIL bw_rdata: got rv=%b%b data=%h required 01 deadbeaa", m0_rvalid, m1_rvalid, m1_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic exp1, prev1;
        prev1 = 0;
        m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h4;
        for (int i = 1; i <= 20; i++) begin
`ifdef JEDRO_1_DMEM_ARB_STARVE_EN
            exp1 = (i % 4 == 0);
`else
            exp1 = 1'b0;
`endif
            @(negedge clk);
            n_tests++;
            if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin
                n_fail++; $display("FAIL contention_gnt cycle %0d: got %b required %b", i, {m0_gnt, m1_gnt}, {~exp1, exp1});
            end
            if (i > 1) begin
                n_tests++;
                if (m1_rvalid !== prev1 || m0_rvalid !== ~prev1) begin
                    n_fail++; $display("FAIL contention_rvalid cycle %0d: got %b%b required %b%b", i, m0_rvalid, m1_rvalid, ~prev1, prev1);
                end
            end
            prev1 = exp1;
            tick();
        end
        idle_all();
        @(negedge clk);
        tick();
    endtask

    task automatic test_back_to_back();
        m0_req = 1; m0_addr = 32'h0;
        @(negedge clk);
        n_tests++;
        if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b required 1", m0_gnt); end
        tick(); m0_req = 0; m1_req = 1; m1_addr = 32'h4;
        @(negedge clk);
        n_tests++;
        if ({m1_gnt, m0_rvalid, m1_rvalid} !== 3'b110 || m0_rdata !== 32'hA5A50000) begin
            n_fail++; $display("FAIL b2b_first: got gnt1/rv=%b data=%h required 110 a5a50000", {m1_gnt, m0_rvalid, m1_rvalid}, m0_rdata);
        end
        tick(); idle_all();
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h00005A5A) begin
            n_fail++; $display("FAIL b2b_second: got rv=%b%b data=%h required 01 00005a5a", m0_rvalid, m1_rvalid, m1_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        n_tests++;
        if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_pre_gnt: got %b required 1", m0_gnt); end
        tick(); rstn = 0; m1_req = 1; m1_addr = 32'h4;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin
                n_fail++; $display("FAIL rst_mid_quiet %0d: got %b required 0000", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
            end
            tick();
        end
        rstn = 1; m1_req = 0;
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m0_rvalid, m1_rvalid} !== 3'b100) begin
            n_fail++; $display("FAIL rst_release: got gnt0/rv=%b required 100", {m0_gnt, m0_rvalid, m1_rvalid});
        end
        tick(); idle_all();
        @(negedge clk);
        n_tests++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEAA) begin
            n_fail++; $display("FAIL rst_post_read: got rv=%b data=%h required 1 deadbeaa", m0_rvalid, m0_rdata);
        end
        tick();
    endtask

    initial begin
        for (int w = 0; w < 64; w++) begin
            ram_mem[w] = 32'h0;
            ref_mem[w] = 32'h0;
        end
        ram_mem[0] = 32'hA5A50000; ref_mem[0] = 32'hA5A50000;
        ram_mem[1] = 32'h00005A5A; ref_mem[1] = 32'h00005A5A;
        ram_rdata = 32'h0;
        test_reset();
        test_port0();
        test_byte_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jedro_1_dmem_arbiter.md
# jedro_1_dmem_arbiter

Two-port arbiter that shares the single bytewrite data RAM between the jedro_1 core's load/store unit (port 0) and an auxiliary master such as a program loader or debug module (port 1). It sits between both masters and the RAM, grants one access per cycle, and steers the one-cycle-latency read response back to the requester that issued it. Fixed priority favours the core. An optional starvation guard bounds the wait of port 1.

## Interface
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- STARVE_LIMIT, 8, consecutive denied cycles of port 1 before a forced grant; range 1..255; used only with the guard compiled in.
- clk_i  input  1  clock; all state updates on the rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- mN_req_i  input  1  request from port N (N = 0, 1).
- mN_we_i  input  1  1 = write, 0 = read.
- mN_be_i  input  DATA_WIDTH/8  byte enables; writes only.
- mN_addr_i  input  ADDR_WIDTH  byte address.
- mN_wdata_i  input  DATA_WIDTH  write data.
- mN_gnt_o  output  1  access accepted this cycle.
- mN_rvalid_o  output  1  read data valid for port N.
- mN_rdata_o  output  DATA_WIDTH  read data.
- ram_en_o  output  1  RAM access strobe.
- ram_we_o  output  1  RAM write.
- ram_be_o  output  DATA_WIDTH/8  RAM byte enables.
- ram_addr_o  output  ADDR_WIDTH  RAM address.
- ram_wdata_o  output  DATA_WIDTH  RAM write data.
- ram_rdata_i  input  DATA_WIDTH  RAM read data, valid one cycle after the read strobe.

## Operation
- Each cycle, at most one requester is granted.
  - Default winner: port 0 if m0_req_i is high, otherwise port 1 if m1_req_i is high.
  - If both request, port 0 wins unless the starvation guard forces port 1.
- The grant is combinational. The winner's we/be/addr/wdata drive the ram_* outputs and ram_en_o = 1 in the same cycle.
- When there is no winner:
  - ram_en_o = 0.
  - ram_we_o = 0.
  - ram_be_o = 0.
  - ram_addr_o and ram_wdata_o are driven to 0.
- For a read grant, the owner register owner_q latches the winning port and rd_pend_q is set to 1.
  - Next cycle, rvalid of owner_q = 1 and that port's rdata = ram_rdata_i. The other port's rvalid = 0.
  - Both rdata outputs always mirror ram_rdata_i; rvalid qualifies them.
- Write grants produce no rvalid.
- A requester holds req and all command fields stable until it sees gnt. It may drop req afterwards or issue back-to-back requests.
- A grant each cycle is legal: the read response for cycle N overlaps the command for cycle N+1.
- Reads ignore be; the full word is returned.

## Timing
- Grant latency: 0 cycles when uncontested.
- Read data latency: exactly 1 cycle after gnt.
- Throughput: 1 access per cycle.
- Reset values, applied immediately and asynchronously:
  - owner_q = 0.
  - rd_pend_q = 0.
  - starve_cnt_q = 0.
  - While rstn_i is low, all mN_gnt_o are 0, ram_en_o is 0, and all rvalid are 0.
- Reset mid-read: the pending response is dropped and no rvalid is issued after reset release.
- Release: the first grant is possible in the first clock cycle with rstn_i high.

## Configuration
- JEDRO_1_DMEM_ARB_STARVE_EN defined:
  - starve_cnt_q increments each cycle that m1_req_i = 1 and m1_gnt_o = 0.
  - starve_cnt_q clears when m1_gnt_o = 1 or m1_req_i = 0.
  - When starve_cnt_q == STARVE_LIMIT, port 1 wins the next arbitration regardless of m0_req_i, and the counter then clears.
  - The counter saturates and never wraps.
- Not defined:
  - Pure fixed priority; port 1 can be starved indefinitely.
  - The counter logic is absent, and STARVE_LIMIT is unused.

## Structure
- Shared package jedro_1_dmem_pkg holds:
  - typedef dmem_port_e (PORT_CORE = 0, PORT_AUX = 1).
  - Localparam BE_WIDTH = DATA_WIDTH/8.
  - typedef dmem_cmd_t, a struct of we, be, addr and wdata, used for the internal mux.
- One sub-module: jedro_1_starve_ctr.
  - Holds the saturating wait counter and the force flag.
  - Instantiated only under JEDRO_1_DMEM_ARB_STARVE_EN.
- The arbiter top holds the grant logic, command mux and response routing.

## Test plan
- Port 0 only:
  - Stimulus: write 0xDEADBEEF to 0x10 with be = 4'b1111, then read 0x10.
  - Required: gnt0 in the same cycle as each request; rvalid0 with rdata 0xDEADBEEF one cycle after the read gnt; rvalid1 stays 0.
- Byte write:
  - Stimulus: port 1 writes 0x000000AA to 0x10 with be = 4'b0001, then reads 0x10.
  - Required: rdata1 = 0xDEADBEAA.
- Contention without the macro:
  - Stimulus: both ports request reads of 0x0 and 0x4 for 20 cycles.
  - Required: gnt0 every cycle; gnt1 never.
- Contention with the macro and STARVE_LIMIT = 3:
  - Stimulus: same as the previous scenario.
  - Required: gnt1 in cycle 4, then every 4th cycle; rvalid1 one cycle after each gnt1; owner routing is correct.
- Back-to-back reads:
  - Stimulus: port 0 reads in cycle N and port 1 reads in cycle N+1 (port 0 idle).
  - Required: rvalid0 in N+1 and rvalid1 in N+2, each with the correct data.
- Reset mid-read:
  - Stimulus: assert rstn_i low in the cycle after a read gnt.
  - Required: no rvalid on either port; all gnt = 0 during reset; a normal grant in the first cycle after release.
